ex_mem_queue: RTL and testbench

Parametrised EX→MEM stage buffer: the next-generation replacement for the single-entry EX/MEM pipeline register. Holds up to DEPTH execute-stage results in a circular queue, decoupling EX from MEM with a valid/ready handshake, so EX keeps retiring while MEM waits on slow UART/memory accesses. Supports a flush for branch mispredicts and reads out as the all-zero NOP payload when empty.

---
 rtl/ex_mem_queue.sv | 79 +++++++
 tb/tb_ex_mem_queue.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ex_mem_queue.sv
// EX->MEM stage buffer: DEPTH-entry circular queue between execute and memory stages.
// Optional EX back-pressure statistics counter is built when EX_MEM_STATS_EN is defined.
module ex_mem_queue #(
  parameter int PAYLOAD_W = 112,
  parameter int DEPTH     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       ex_valid,
  output logic                       ex_ready,
  input  logic [PAYLOAD_W-1:0]       ex_payload,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [PAYLOAD_W-1:0]       mem_payload,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic [31:0]                stall_cycles
);

  localparam int AW = $clog2(DEPTH);

  logic [PAYLOAD_W-1:0] mem [DEPTH];
  logic [AW-1:0]        wp;
  logic [AW-1:0]        rp;
  logic [AW:0]          cnt;
  logic                 push;
  logic                 pop;

  // Handshake: a transfer happens on a rising edge where valid && ready. ready never
  // depends on the partner's valid, and there is no pass-through when full.
  assign full        = (cnt == (AW+1)'(DEPTH));
  assign empty       = (cnt == '0);
  assign count       = cnt;
  assign ex_ready    = !full && !rst;
  assign mem_valid   = !empty;
  assign mem_payload = empty ? '0 : mem[rp];
  assign push        = ex_valid && ex_ready;
  assign pop         = mem_valid && mem_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is never cleared; empty gates it off the output.
  always_ff @(posedge clk) begin
    if (!flush && push) mem[wp] <= ex_payload;
  end

`ifdef EX_MEM_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (ex_valid && !ex_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_ex_mem_queue.sv
// Bench for ex_mem_queue: directed scenarios plus random traffic checked against a
// payload-queue reference model.
module tb_ex_mem_queue;

  localparam int W     = 112;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic           ex_valid;
  logic           ex_ready;
  logic [W-1:0]   ex_payload;
  logic           mem_valid;
  logic           mem_ready;
  logic [W-1:0]   mem_payload;
  logic [CW-1:0]  count;
  logic           full;
  logic           empty;
  logic [31:0]    stall_cycles;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [W-1:0] exp_q[$];
  longint       m_stall = 0;

  ex_mem_queue #(.PAYLOAD_W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_payload(ex_payload),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_payload(mem_payload),
    .count(count), .full(full), .empty(empty), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_payload();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  // One clock: drive inputs, check outputs against the model, take the edge, update the model.
  task automatic cycle(input logic r, input logic f, input logic v, input logic [W-1:0] pl,
                       input logic mr);
    int     n;
    logic   m_ready;
    logic   do_push;
    logic   do_pop;
    longint exp_stall;
    rst = r; flush = f; ex_valid = v; ex_payload = pl; mem_ready = mr;
    #1;
    n       = exp_q.size();
    m_ready = (n < DEPTH) && !r;
    do_push = v && m_ready;
    do_pop  = (n > 0) && mr;
`ifdef EX_MEM_STATS_EN
    exp_stall = m_stall;
`else
    exp_stall = 0;
`endif
    check("count",        128'(count),       128'(n));
    check("empty",        128'(empty),       128'(n == 0));
    check("full",         128'(full),        128'(n == DEPTH));
    check("mem_valid",    128'(mem_valid),   128'(n > 0));
    check("mem_payload",  128'(mem_payload), (n > 0) ? 128'(exp_q[0]) : 128'(0));
    check("ex_ready",     128'(ex_ready),    128'(m_ready));
    check("stall_cycles", 128'(stall_cycles), 128'(exp_stall));
    if (v && !m_ready && !r && m_stall < 64'hFFFF_FFFF) m_stall++;
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      m_stall = 0;
    end else if (f) begin
      exp_q.delete();
    end else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(pl);
    end
  endtask

  initial begin
    logic [W-1:0] z;
    z = '0;
    rst = 1'b1; flush = 1'b0; ex_valid = 1'b1; ex_payload = W'('hDEAD); mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // reset held with ex_valid high: nothing may be queued
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, W'('hDEAD), 1'b0);
    cycle(1'b0, 1'b0, 1'b0, z, 1'b0);

    // fill to full, A5 held off, then drain in order with A5 following
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b0, 1'b1, W'('hA0 + i), 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b1, W'('hA5), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, W'('hA5), 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, z, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, z, 1'b0);

    // stall hold: head 0x55 must stay stable
    cycle(1'b0, 1'b1, 1'b0, z, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, W'('h55), 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, z, 1'b0);

    // steady push+pop at count 2 across pointer wrap
    cycle(1'b0, 1'b1, 1'b0, z, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, W'('h100), 1'b0);
    cycle(1'b0, 1'b0, 1'b1, W'('h101), 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, W'('h200 + i), 1'b1);
    cycle(1'b0, 1'b0, 1'b0, z, 1'b0);

    // flush with simultaneous push and pop at count 3
    cycle(1'b0, 1'b1, 1'b0, z, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, W'('h300 + i), 1'b0);
    cycle(1'b0, 1'b1, 1'b1, W'('hBAD), 1'b1);
    cycle(1'b0, 1'b0, 1'b0, z, 1'b1);

    // back-pressure statistics: 7 stalled cycles, then a flush that must not clear them
    cycle(1'b1, 1'b0, 1'b0, z, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, W'('h400 + i), 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b1, W'('h4FF), 1'b0);
    cycle(1'b0, 1'b1, 1'b0, z, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, z, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 4,
            $urandom_range(0, 99) < 65, rand_payload(), $urandom_range(0, 99) < 55);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
